// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padding stream.
package sha256_pkg;

  localparam int unsigned BLOCK_BYTES     = 64;
  localparam int unsigned LEN_FIELD_BYTES = 8;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StEmit,
    StPad2,
    StEmit2
  } pad_state_e;

  // Tail block flavours produced by pad_tail_builder.
  typedef enum logic [1:0] {
    TailSingle,   // data, 0x80 at p_final, zeros, length
    TailNoLen,    // data, 0x80 at p_final, zeros
    TailPadLen,   // 0x80 at byte 0, zeros, length
    TailLenOnly   // zeros, length
  } tail_mode_e;

endpackage

// File: rtl/pad_tail_builder.sv
// Combinational builder for the final padded block(s) of a message.
module pad_tail_builder
  import sha256_pkg::*;
(
  input  logic [8*BLOCK_BYTES-1:0] buf_i,
  input  logic [5:0]               p_final_i,
  input  logic [63:0]              bitlen_i,
  input  tail_mode_e               mode_i,
  output logic [8*BLOCK_BYTES-1:0] blk_o
);

  logic       data_en;
  logic       pad_en;
  logic       len_en;
  logic [5:0] pad_pos;

  always_comb begin
    data_en = 1'b0;
    pad_en  = 1'b1;
    len_en  = 1'b1;
    pad_pos = p_final_i;
    unique case (mode_i)
      TailSingle:  data_en = 1'b1;
      TailNoLen: begin
        data_en = 1'b1;
        len_en  = 1'b0;
      end
      TailPadLen:  pad_pos = 6'd0;
      TailLenOnly: pad_en  = 1'b0;
      default: ;
    endcase

    blk_o = '0;
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      if (data_en && (b < int'(p_final_i))) begin
        blk_o[8*(BLOCK_BYTES-1-b) +: 8] = buf_i[8*(BLOCK_BYTES-1-b) +: 8];
      end else if (pad_en && (b == int'(pad_pos))) begin
        blk_o[8*(BLOCK_BYTES-1-b) +: 8] = PAD_BYTE;
      end
    end
    // Single-block mode is only chosen when p_final <= 55, so this never hits the 0x80 byte.
    if (len_en) begin
      blk_o[8*LEN_FIELD_BYTES-1:0] = bitlen_i;
    end
  end

endmodule

// File: rtl/msg_padder_stream.sv
// Streams message bytes into 512-bit blocks and appends SHA-256 style padding and length.
module msg_padder_stream
  import sha256_pkg::*;
#(
  parameter int unsigned BEAT_BYTES    = 1,
  parameter int unsigned MAX_MSG_BYTES = 1024,
  parameter int unsigned CNT_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [8*BEAT_BYTES-1:0]        in_data,
  input  logic                           in_last,
  input  logic [$clog2(BEAT_BYTES+1)-1:0] in_nbytes,
  output logic                           blk_valid,
  input  logic                           blk_ready,
  output logic [8*BLOCK_BYTES-1:0]       blk_data,
  output logic                           blk_last,
  output logic                           busy,
  output logic                           err_overflow
);

  localparam int unsigned NB_W = $clog2(BEAT_BYTES + 1);
  // Wide enough for the 6-bit block offset and one beat of headroom above MAX_MSG_BYTES.
  localparam int unsigned CW   = ((CNT_W > 6) ? CNT_W : 6) + 1;

  pad_state_e               state_q, state_d;
  logic [8*BLOCK_BYTES-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [8*BLOCK_BYTES-1:0] blk_data_q, blk_data_d;
  logic                     blk_last_q, blk_last_d;
  logic                     err_q, err_d;
  logic                     pad80_q, pad80_d;
  logic                     done_q, done_d;

  logic [NB_W-1:0]          beat_n;
  logic [CW-1:0]            count_w;
  logic [CW-1:0]            sum;
  logic [5:0]               ptr;
  logic [5:0]               p_final;
  logic                     overflow;
  logic [8*BLOCK_BYTES-1:0] merged;
  tail_mode_e               tail_mode;
  logic [63:0]              tail_bitlen;
  logic [8*BLOCK_BYTES-1:0] tail_blk;

  assign beat_n   = in_last ? in_nbytes : NB_W'(BEAT_BYTES);
  assign count_w  = CW'(count_q);
  assign sum      = count_w + CW'(beat_n);
  assign ptr      = count_w[5:0];
  assign p_final  = sum[5:0];
  assign overflow = (sum > CW'(MAX_MSG_BYTES));

  // Beats never straddle a block boundary since BEAT_BYTES divides 64.
  always_comb begin
    merged = buf_q;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if (k < int'(beat_n)) begin
        merged[8*(BLOCK_BYTES-1-((int'(ptr)+k) % BLOCK_BYTES)) +: 8] =
          in_data[8*(BEAT_BYTES-1-k) +: 8];
      end
    end
  end

  pad_tail_builder u_tail (
    .buf_i     (merged),
    .p_final_i (p_final),
    .bitlen_i  (tail_bitlen),
    .mode_i    (tail_mode),
    .blk_o     (tail_blk)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    blk_data_d  = blk_data_q;
    blk_last_d  = blk_last_q;
    err_d       = err_q;
    pad80_d     = pad80_q;
    done_d      = done_q;
    tail_mode   = (p_final <= 6'd55) ? TailSingle : TailNoLen;
    tail_bitlen = 64'({sum[CNT_W-1:0], 3'b000});

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          buf_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          pad80_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      StFill: begin
        if (in_valid) begin
          if (overflow) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            count_d = sum[CNT_W-1:0];
            if (in_last) begin
              done_d  = 1'b1;
              buf_d   = '0;
              state_d = StEmit;
              // Last beat exactly filled the block: padding goes entirely into a second block.
              if ((beat_n != '0) && (p_final == 6'd0)) begin
                blk_data_d = merged;
                blk_last_d = 1'b0;
                pad80_d    = 1'b1;
              end else begin
                blk_data_d = tail_blk;
                blk_last_d = (p_final <= 6'd55);
                pad80_d    = 1'b0;
              end
            end else if (p_final == 6'd0) begin
              blk_data_d = merged;
              blk_last_d = 1'b0;
              buf_d      = '0;
              state_d    = StEmit;
            end else begin
              buf_d = merged;
            end
          end
        end
      end
      StEmit: begin
        if (blk_ready) begin
          if (blk_last_q) begin
            state_d = StIdle;
          end else if (done_q) begin
            state_d = StPad2;
          end else begin
            state_d = StFill;
          end
        end
      end
      StPad2: begin
        tail_mode   = pad80_q ? TailPadLen : TailLenOnly;
        tail_bitlen = 64'({count_q, 3'b000});
        blk_data_d  = tail_blk;
        blk_last_d  = 1'b1;
        state_d     = StEmit2;
      end
      StEmit2: begin
        if (blk_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      count_q    <= '0;
      blk_data_q <= '0;
      blk_last_q <= 1'b0;
      err_q      <= 1'b0;
      pad80_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      blk_data_q <= blk_data_d;
      blk_last_q <= blk_last_d;
      err_q      <= err_d;
      pad80_q    <= pad80_d;
      done_q     <= done_d;
    end
  end

  assign in_ready     = (state_q == StFill);
  assign blk_valid    = (state_q == StEmit) || (state_q == StEmit2);
  assign blk_data     = blk_data_q;
  assign blk_last     = blk_last_q;
  assign busy         = (state_q != StIdle);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_msg_padder_stream.sv
// Directed bench for msg_padder_stream: three instances (1-byte, 4-byte, small-max) share stimulus.
module tb_msg_padder_stream;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_ready;
  int           sel;

  logic         r1_in_ready, r4_in_ready, rs_in_ready;
  logic         r1_blk_valid, r4_blk_valid, rs_blk_valid;
  logic [511:0] r1_blk_data, r4_blk_data, rs_blk_data;
  logic         r1_blk_last, r4_blk_last, rs_blk_last;
  logic         r1_busy, r4_busy, rs_busy;
  logic         r1_err, r4_err, rs_err;

  logic         m_in_ready, m_blk_valid, m_blk_last, m_busy, m_err;
  logic [511:0] m_blk_data;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;

  always #5 clock = ~clock;

  msg_padder_stream #(.BEAT_BYTES(1)) u_dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start && (sel == 0)),
    .in_valid     (in_valid && (sel == 0)),
    .in_ready     (r1_in_ready),
    .in_data      (in_data[31:24]),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes[0:0]),
    .blk_valid    (r1_blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (r1_blk_data),
    .blk_last     (r1_blk_last),
    .busy         (r1_busy),
    .err_overflow (r1_err)
  );

  msg_padder_stream #(.BEAT_BYTES(4)) u_dut4 (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start && (sel == 1)),
    .in_valid     (in_valid && (sel == 1)),
    .in_ready     (r4_in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes),
    .blk_valid    (r4_blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (r4_blk_data),
    .blk_last     (r4_blk_last),
    .busy         (r4_busy),
    .err_overflow (r4_err)
  );

  msg_padder_stream #(.BEAT_BYTES(1), .MAX_MSG_BYTES(16)) u_duts (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start && (sel == 2)),
    .in_valid     (in_valid && (sel == 2)),
    .in_ready     (rs_in_ready),
    .in_data      (in_data[31:24]),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes[0:0]),
    .blk_valid    (rs_blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (rs_blk_data),
    .blk_last     (rs_blk_last),
    .busy         (rs_busy),
    .err_overflow (rs_err)
  );

  always_comb begin
    m_in_ready  = r1_in_ready;
    m_blk_valid = r1_blk_valid;
    m_blk_data  = r1_blk_data;
    m_blk_last  = r1_blk_last;
    m_busy      = r1_busy;
    m_err       = r1_err;
    if (sel == 1) begin
      m_in_ready  = r4_in_ready;
      m_blk_valid = r4_blk_valid;
      m_blk_data  = r4_blk_data;
      m_blk_last  = r4_blk_last;
      m_busy      = r4_busy;
      m_err       = r4_err;
    end else if (sel == 2) begin
      m_in_ready  = rs_in_ready;
      m_blk_valid = rs_blk_valid;
      m_blk_data  = rs_blk_data;
      m_blk_last  = rs_blk_last;
      m_busy      = rs_busy;
      m_err       = rs_err;
    end
  end

  always @(negedge clock) begin
    if (m_blk_valid) vcnt <= vcnt + 1;
  end

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit got = 1'b0;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m_in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_val("accept_timeout", 512'd0, 512'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      send_beat({b, 24'h0}, last && (i == n - 1), 3'd1);
    end
  endtask

  task automatic get_block(output logic [511:0] d, output logic l);
    bit got = 1'b0;
    d = 'x;
    l = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m_blk_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check_val("block_timeout", 512'd0, 512'd1);
    end else begin
      d = m_blk_data;
      l = m_blk_last;
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
    end
  endtask

  logic [511:0] blk;
  logic         lst;
  int           v0;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = '0;
    blk_ready = 1'b0;
    sel       = 0;
    repeat (3) @(negedge clock);
    check_val("rst_in_ready",  512'(m_in_ready),  512'd0);
    check_val("rst_blk_valid", 512'(m_blk_valid), 512'd0);
    check_val("rst_blk_last",  512'(m_blk_last),  512'd0);
    check_val("rst_busy",      512'(m_busy),      512'd0);
    check_val("rst_err",       512'(m_err),       512'd0);
    check_val("rst_blk_data",  m_blk_data,        512'd0);
    reset_n = 1'b1;
    tick();

    // "abc", 1-byte beats
    sel = 0;
    do_start();
    send_beat(32'h61000000, 1'b0, 3'd1);
    send_beat(32'h62000000, 1'b0, 3'd1);
    send_beat(32'h63000000, 1'b1, 3'd1);
    check_val("abc_latency", 512'(m_blk_valid), 512'd1);
    get_block(blk, lst);
    check_val("abc_data", blk, {32'h61626380, 416'd0, 64'h18});
    check_val("abc_last", 512'(lst), 512'd1);
    check_val("abc_idle", 512'(m_busy), 512'd0);

    // empty message
    do_start();
    send_beat(32'h0, 1'b1, 3'd0);
    get_block(blk, lst);
    check_val("empty_data", blk, {8'h80, 504'd0});
    check_val("empty_last", 512'(lst), 512'd1);

    // 56 bytes: padding spills into a second block
    do_start();
    send_bytes(8'h61, 56, 1'b1);
    get_block(blk, lst);
    check_val("b56_blk1", blk, {{56{8'h61}}, 8'h80, 56'd0});
    check_val("b56_last1", 512'(lst), 512'd0);
    get_block(blk, lst);
    check_val("b56_blk2", blk, {448'd0, 64'h1C0});
    check_val("b56_last2", 512'(lst), 512'd1);

    // 64 bytes in 4-byte beats: exact fill by the last beat
    sel = 1;
    do_start();
    for (int i = 0; i < 16; i++) send_beat(32'hDEADBEEF, (i == 15), 3'd4);
    get_block(blk, lst);
    check_val("b64_blk1", blk, {16{32'hDEADBEEF}});
    check_val("b64_last1", 512'(lst), 512'd0);
    get_block(blk, lst);
    check_val("b64_blk2", blk, {8'h80, 440'd0, 64'h200});
    check_val("b64_last2", 512'(lst), 512'd1);

    // "abcde" with a partial last beat carrying junk in unused lanes
    do_start();
    send_beat(32'h61626364, 1'b0, 3'd4);
    send_beat(32'h65FFFFFF, 1'b1, 3'd1);
    get_block(blk, lst);
    check_val("abcde_data", blk, {40'h6162636465, 8'h80, 400'd0, 64'h28});
    check_val("abcde_last", 512'(lst), 512'd1);

    // backpressure: block held stable for 5 cycles
    sel = 0;
    do_start();
    send_beat(32'h61000000, 1'b0, 3'd1);
    send_beat(32'h62000000, 1'b0, 3'd1);
    send_beat(32'h63000000, 1'b1, 3'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val("stall_data", m_blk_data, {32'h61626380, 416'd0, 64'h18});
      check_val("stall_in_ready", 512'(m_in_ready), 512'd0);
      check_val("stall_valid", 512'(m_blk_valid), 512'd1);
    end
    get_block(blk, lst);
    check_val("stall_final", blk, {32'h61626380, 416'd0, 64'h18});

    // reset mid-FILL abandons the message
    do_start();
    send_beat(32'h61000000, 1'b0, 3'd1);
    send_beat(32'h62000000, 1'b0, 3'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_mid_busy", 512'(m_busy), 512'd0);
    check_val("rst_mid_in_ready", 512'(m_in_ready), 512'd0);
    @(negedge clock);
    reset_n = 1'b1;
    v0 = vcnt;
    repeat (10) @(negedge clock);
    check_val("rst_mid_no_blk", 512'(vcnt - v0), 512'd0);
    check_val("rst_mid_idle", 512'(m_busy), 512'd0);

    // overflow with MAX_MSG_BYTES=16
    sel = 2;
    v0  = vcnt;
    do_start();
    send_bytes(8'h41, 17, 1'b1);
    tick();
    check_val("ovf_err", 512'(m_err), 512'd1);
    check_val("ovf_idle", 512'(m_busy), 512'd0);
    check_val("ovf_in_ready", 512'(m_in_ready), 512'd0);
    check_val("ovf_no_blk", 512'(vcnt - v0), 512'd0);
    do_start();
    check_val("ovf_err_clear", 512'(m_err), 512'd0);
    send_beat(32'h0, 1'b1, 3'd0);
    get_block(blk, lst);
    check_val("ovf_after_empty", blk, {8'h80, 504'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_padder_stream.md
MSG_PADDER_STREAM -- requirements
Module: msg_padder_stream

Interface
REQ-001 SHALL have parameter BEAT_BYTES, default 1, meaning input bytes per beat; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter MAX_MSG_BYTES, default 1024, meaning the largest accepted message length in bytes.
REQ-003 SHALL have parameter CNT_W, default $clog2(MAX_MSG_BYTES+1), meaning the byte-counter width.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that begins a new message; honoured only in IDLE.
REQ-007 SHALL have port in_valid / in_ready, input / output, 1 each, the byte-beat handshake.
REQ-008 SHALL have port in_data, input, 8*BEAT_BYTES, message bytes, with the first byte in the MSBs.
REQ-009 SHALL have port in_last, input, 1, marking the final beat of the message.
REQ-010 SHALL have port in_nbytes, input, $clog2(BEAT_BYTES+1), the count of valid bytes in the last beat (0..BEAT_BYTES); it is ignored unless in_last is high.
REQ-011 SHALL have port blk_valid / blk_ready, output / input, 1 each, the block handshake.
REQ-012 SHALL have port blk_data, output, 512, the padded block, with byte 0 at bits 511:504.
REQ-013 SHALL have port blk_last, output, 1, marking the final block of the message.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port err_overflow, output, 1, a sticky flag raised when the message exceeds MAX_MSG_BYTES.

Function
REQ-016 SHALL implement the states IDLE, FILL, EMIT, PAD2 and EMIT2.
- IDLE -> FILL on start; the block buffer and byte counter are cleared.
REQ-017 SHALL in FILL assert in_ready; each accepted beat writes its bytes at offset p = count mod 64, and count advances by BEAT_BYTES (or by in_nbytes on the last beat).
REQ-018 SHALL go FILL -> EMIT with blk_last=0 when the block fills (p wraps to 0) on a beat without in_last; after the handshake it returns to FILL with the buffer cleared.
REQ-019 SHALL, on the in_last beat, write 0x80 at offset p_final = count_final mod 64 and zero all bytes above it.
- If p_final <= 55, it writes the 64-bit big-endian bit length (count*8) into bytes 56..63 and goes to EMIT with blk_last=1.
- Otherwise it goes to EMIT with blk_last=0, then to PAD2.
REQ-020 SHALL handle a block filled exactly by the last beat (p_final == 0) as follows: EMIT the full data block with blk_last=0, then PAD2 builds 0x80, zeros, and the length.
REQ-021 SHALL have PAD2 build a block of zeros plus the length (plus 0x80 at byte 0 only in the REQ-020 case), go to EMIT2 with blk_last=1, then return to IDLE.
REQ-022 SHALL hold blk_data and blk_last stable while blk_valid is high and blk_ready is low; in_ready is 0 in every state except FILL.
REQ-023 SHALL have a latency of exactly one cycle from the accepting edge of the beat that completes a block to blk_valid high.
REQ-024 SHALL treat in_last with in_nbytes=0 as the end of the message with no extra bytes.
- A zero-length message yields one block: 0x80 followed by 63 zero bytes.
REQ-025 SHALL, if count would exceed MAX_MSG_BYTES, set err_overflow, drop the beat, and return to IDLE without emitting.
- err_overflow clears on the next start.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL give in_valid and start no meaning during EMIT, EMIT2 and PAD2.
REQ-028 SHALL compute the length field from the full 64-bit value count*8 zero-extended from CNT_W+3 bits; there is no truncation.

Reset
REQ-029 SHALL, while reset_n is low, force the state to IDLE, set in_ready, blk_valid, blk_last, busy and err_overflow to 0, and clear blk_data and the counter to 0, all without a clock edge.
REQ-030 SHALL abandon a message on reset assertion mid-message or mid-handshake; no partial block is emitted after release.

Structure
REQ-031 SHALL place the state enum, BLOCK_BYTES=64, LEN_FIELD_BYTES=8, and PAD_BYTE=8'h80 in the shared package sha256_pkg.
REQ-032 SHALL instantiate one sub-module, pad_tail_builder, which is combinational; it takes the buffer, p_final, the bit length and a mode, and returns the tail block.

Verification
REQ-033 SHALL cover "abc" with BEAT_BYTES=1: expect one block, 61626380 followed by zeros with length 0x18, and blk_last=1.
REQ-034 SHALL cover an empty message (start, then an in_last beat with in_nbytes=0): expect one block with byte0=0x80 and all other bytes zero, blk_last=1.
REQ-035 SHALL cover 56 bytes of 0x61: expect block 1 with bytes 0..55 data, byte 56 = 0x80, rest zero, blk_last=0; then block 2 with zeros and length 0x1C0, blk_last=1.
REQ-036 SHALL cover 64 bytes with BEAT_BYTES=4: expect block 1 to be the pure data, blk_last=0; then block 2 with 0x80 at byte0 and length 0x200, blk_last=1.
REQ-037 SHALL cover blk_ready held low for 5 cycles: blk_data must stay stable and in_ready stay 0; reset_n pulsed mid-FILL must return to IDLE with no block emitted.
REQ-038 SHALL cover MAX_MSG_BYTES=16 with 17 bytes sent: expect err_overflow=1, no blk_valid, and state IDLE.
